multi_mode_mult_seq: RTL and testbench

- Row-serial, parametrised successor to the fully parallel multi-mode multiplier.
- Computes LOW, HIGH, SQUARE or FULL products of two NUM_ELEMENTS-digit redundant operands, with an optional add term.
- Uses NUM_ELEMENTS DSP lanes over 2·NUM_ELEMENTS cycles instead of NUM_ELEMENTS² multipliers.
- Sits between the modular-squaring controller and the reduction stage, behind a valid/ready handshake; the result is carry-normalised.

---
 rtl/mmm_pkg.sv | 23 ++
 rtl/mmm_row_mac.sv | 22 ++
 rtl/multi_mode_mult_seq.sv | 210 +++++++++++++++++++++
 tb/tb_multi_mode_mult_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmm_pkg.sv
// Shared types and sizing helper for the row-serial multi-mode multiplier.
package mmm_pkg;

    typedef enum logic [1:0] {
        MODE_LOW  = 2'd0,
        MODE_HIGH = 2'd1,
        MODE_SQR  = 2'd2,
        MODE_FULL = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Column width: one full product per lane, headroom for NUM_ELEMENTS additions plus the add term.
    function automatic int acc_bit_len(input int dsp_bit_len, input int num_elements);
        return 2 * dsp_bit_len + $clog2(num_elements + 1) + 1;
    endfunction

endpackage

// File: rtl/mmm_row_mac.sv
// One multiplier row: NUM_ELEMENTS parallel lanes computing win[j] + a * b[j].
module mmm_row_mac #(
    parameter int NUM_ELEMENTS = 16,
    parameter int DSP_BIT_LEN  = 17,
    parameter int ACC_BIT_LEN  = 40
) (
    input  logic [DSP_BIT_LEN-1:0]              i_a,
    input  logic [NUM_ELEMENTS*DSP_BIT_LEN-1:0] i_b,
    input  logic [NUM_ELEMENTS*ACC_BIT_LEN-1:0] i_win,
    output logic [NUM_ELEMENTS*ACC_BIT_LEN-1:0] o_win
);

    localparam int D   = DSP_BIT_LEN;
    localparam int ACC = ACC_BIT_LEN;

    for (genvar j = 0; j < NUM_ELEMENTS; j++) begin : g_lane
        logic [2*D-1:0] prod;
        assign prod = {{D{1'b0}}, i_a} * {{D{1'b0}}, i_b[j*D +: D]};
        assign o_win[j*ACC +: ACC] = i_win[j*ACC +: ACC] + {{(ACC-2*D){1'b0}}, prod};
    end

endmodule

// File: rtl/multi_mode_mult_seq.sv
// Row-serial LOW/HIGH/SQUARE/FULL multiplier with carry-normalised output and valid/ready handshakes.
// Define MMM_ADD_TERM_EN to load i_add_term into the accumulator on accept; otherwise it is ignored.
module multi_mode_mult_seq
    import mmm_pkg::*;
#(
    parameter int NUM_ELEMENTS = 16,
    parameter int DSP_BIT_LEN  = 17,
    parameter int WORD_LEN     = 16
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_val,
    output logic                                  o_rdy,
    input  logic [1:0]                            i_ctl,
    input  logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]   i_dat_a,
    input  logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]   i_dat_b,
    input  logic [DSP_BIT_LEN*NUM_ELEMENTS-1:0]   i_add_term,
    output logic                                  o_val,
    input  logic                                  i_rdy,
    output logic [DSP_BIT_LEN*2*NUM_ELEMENTS-1:0] o_dat,
    output logic [1:0]                            o_ctl,
    output logic                                  o_ovf
);

    localparam int N     = NUM_ELEMENTS;
    localparam int D     = DSP_BIT_LEN;
    localparam int W     = WORD_LEN;
    localparam int ACC   = acc_bit_len(D, N);
    localparam int CW    = ACC - W;
    localparam int CNT_W = $clog2(N);
    localparam int IDX_W = $clog2(2 * N);

    // Input handshake: a request transfers on an edge where i_val && o_rdy.
    // Output handshake: o_val holds with stable o_dat/o_ctl/o_ovf until an edge with i_rdy.
    state_e                   state_q, state_d;
    mode_e                    mode_q, mode_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [N-1:0][D-1:0]      a_q, a_d, b_q, b_d;
    logic [2*N-1:0][ACC-1:0]  acc_q, acc_d;
    logic [CW-1:0]            carry_q, carry_d;
    logic [2*N-1:0][D-1:0]    res_q, res_d;
    logic                     ovf_q, ovf_d;
    logic                     arm_q, arm_d;
    logic                     o_val_q, o_val_d;
    logic                     o_rdy_q, o_rdy_d;
    logic [2*N-1:0][D-1:0]    o_dat_q, o_dat_d;
    mode_e                    o_ctl_q, o_ctl_d;
    logic                     o_ovf_q, o_ovf_d;

    logic [N-1:0][ACC-1:0]    win_in, win_out;
    logic [N-1:0][D-1:0]      add_t;
    logic [IDX_W-1:0]         row_base, col_idx;
    logic [ACC-1:0]           col_sum;
    logic                     accept;

    assign add_t    = i_add_term;
    assign row_base = IDX_W'(cnt_q);
    assign col_idx  = IDX_W'(N) + row_base;
    // arm_q keeps the reset-release edge from accepting a request.
    assign accept   = i_val && o_rdy_q && arm_q;

`ifndef MMM_ADD_TERM_EN
    logic unused_add_term;
    assign unused_add_term = ^add_t;
`endif

    for (genvar j = 0; j < N; j++) begin : g_win
        assign win_in[j] = acc_q[row_base + IDX_W'(j)];
    end

    mmm_row_mac #(
        .NUM_ELEMENTS(N),
        .DSP_BIT_LEN (D),
        .ACC_BIT_LEN (ACC)
    ) u_row_mac (
        .i_a  (a_q[cnt_q]),
        .i_b  (b_q),
        .i_win(win_in),
        .o_win(win_out)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        arm_d   = 1'b1;
        o_val_d = o_val_q;
        o_dat_d = o_dat_q;
        o_ctl_d = o_ctl_q;
        o_ovf_d = o_ovf_q;
        col_sum = '0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mode_d  = mode_e'(i_ctl);
                    a_d     = i_dat_a;
                    b_d     = (mode_e'(i_ctl) == MODE_SQR) ? i_dat_a : i_dat_b;
                    acc_d   = '0;
`ifdef MMM_ADD_TERM_EN
                    for (int k = 0; k < N; k++) begin
                        acc_d[k] = {{(ACC-D){1'b0}}, add_t[k]};
                    end
`endif
                    carry_d = '0;
                    cnt_d   = '0;
                    res_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                for (int j = 0; j < N; j++) begin
                    acc_d[row_base + IDX_W'(j)] = win_out[j];
                end
                // Column cnt receives no further products, so normalise it in the same cycle.
                col_sum         = win_out[0] + {{W{1'b0}}, carry_q};
                res_d[row_base] = {{(D-W){1'b0}}, col_sum[W-1:0]};
                carry_d         = col_sum[ACC-1:W];
                if (cnt_q == CNT_W'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = (mode_q == MODE_LOW) ? S_DONE : S_NORM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_NORM: begin
                col_sum = acc_q[col_idx] + {{W{1'b0}}, carry_q};
                if (cnt_q == CNT_W'(N - 1)) begin
                    res_d[col_idx] = col_sum[D-1:0];
                    ovf_d          = |col_sum[ACC-1:D];
                    cnt_d          = '0;
                    state_d        = S_DONE;
                end else begin
                    res_d[col_idx] = {{(D-W){1'b0}}, col_sum[W-1:0]};
                    carry_d        = col_sum[ACC-1:W];
                    cnt_d          = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (!o_val_q) begin
                    for (int k = 0; k < 2 * N; k++) begin
                        o_dat_d[k] = res_q[k];
                        if ((mode_q == MODE_LOW && k >= N) || (mode_q == MODE_HIGH && k < N)) begin
                            o_dat_d[k] = '0;
                        end
                    end
                    o_ctl_d = mode_q;
                    o_ovf_d = (mode_q != MODE_LOW) && ovf_q;
                    o_val_d = 1'b1;
                end else if (i_rdy) begin
                    o_val_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        o_rdy_d = (state_d == S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_LOW;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            arm_q   <= 1'b0;
            o_val_q <= 1'b0;
            o_rdy_q <= 1'b1;
            o_dat_q <= '0;
            o_ctl_q <= MODE_LOW;
            o_ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            arm_q   <= arm_d;
            o_val_q <= o_val_d;
            o_rdy_q <= o_rdy_d;
            o_dat_q <= o_dat_d;
            o_ctl_q <= o_ctl_d;
            o_ovf_q <= o_ovf_d;
        end
    end

    assign o_val = o_val_q;
    assign o_rdy = o_rdy_q;
    assign o_dat = o_dat_q;
    assign o_ctl = o_ctl_q;
    assign o_ovf = o_ovf_q;

endmodule

// File: tb/tb_multi_mode_mult_seq.sv
// Bench for multi_mode_mult_seq (N=4, 17-bit digits, radix 2^16) against a big-integer product model.
module tb_multi_mode_mult_seq;

    localparam int N     = 4;
    localparam int D     = 17;
    localparam int W     = 16;
    localparam int DW    = D * N;
    localparam int OW    = 2 * N * D;
    localparam int EXP_W = OW + 3;
`ifdef MMM_ADD_TERM_EN
    localparam bit ADD_EN = 1'b1;
`else
    localparam bit ADD_EN = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_val = 1'b0;
    logic          i_rdy = 1'b0;
    logic [1:0]    i_ctl = 2'd0;
    logic [DW-1:0] i_dat_a = '0;
    logic [DW-1:0] i_dat_b = '0;
    logic [DW-1:0] i_add_term = '0;
    logic          o_rdy, o_val, o_ovf;
    logic [OW-1:0] o_dat;
    logic [1:0]    o_ctl;

    int n_vec = 0;
    int n_err = 0;
    logic [EXP_W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    multi_mode_mult_seq #(
        .NUM_ELEMENTS(N),
        .DSP_BIT_LEN (D),
        .WORD_LEN    (W)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_val     (i_val),
        .o_rdy     (o_rdy),
        .i_ctl     (i_ctl),
        .i_dat_a   (i_dat_a),
        .i_dat_b   (i_dat_b),
        .i_add_term(i_add_term),
        .o_val     (o_val),
        .i_rdy     (i_rdy),
        .o_dat     (o_dat),
        .o_ctl     (o_ctl),
        .o_ovf     (o_ovf)
    );

    // ---------------- reference model ----------------
    function automatic logic [EXP_W-1:0] model(input logic [1:0] mode, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b, input logic [DW-1:0] t);
        logic [255:0]  p;
        logic [DW-1:0] bb;
        logic [OW-1:0] dat;
        logic          ovf;
        bb = (mode == 2'd2) ? a : b;
        p  = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                p = p + ((256'(a[i*D +: D]) * 256'(bb[j*D +: D])) << (W * (i + j)));
        for (int k = 0; k < N; k++)
            if (ADD_EN) p = p + (256'(t[k*D +: D]) << (W * k));
        for (int k = 0; k < 2 * N; k++) begin
            if (k == 2 * N - 1) dat[k*D +: D] = D'(p >> (W * k));
            else                dat[k*D +: D] = D'((p >> (W * k)) & 256'h0FFFF);
        end
        ovf = ((p >> (W * (2 * N - 1) + D)) != 0);
        if (mode == 2'd0) begin
            dat[OW-1:DW] = '0;
            ovf = 1'b0;
        end
        if (mode == 2'd1) dat[DW-1:0] = '0;
        return {mode, ovf, dat};
    endfunction

    function automatic logic [DW-1:0] rand_op();
        logic [DW-1:0] v;
        for (int k = 0; k < N; k++) v[k*D +: D] = D'($urandom_range(0, (1 << D) - 1));
        return v;
    endfunction

    function automatic logic [DW-1:0] fill(input logic [D-1:0] d);
        logic [DW-1:0] v;
        for (int k = 0; k < N; k++) v[k*D +: D] = d;
        return v;
    endfunction

    // ---------------- scoreboard / checks ----------------
    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [EXP_W-1:0] e);
        for (int k = 0; k < 2 * N; k++)
            check($sformatf("%s w%0d", tag, k), 160'(o_dat[k*D +: D]), 160'(e[k*D +: D]));
        check({tag, " ovf"}, 160'(o_ovf), 160'(e[OW]));
        check({tag, " ctl"}, 160'(o_ctl), 160'(e[OW+2:OW+1]));
        check({tag, " val"}, 160'(o_val), 160'(1));
    endtask

    // ---------------- drivers ----------------
    task automatic send(input logic [1:0] mode, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] t);
        @(negedge i_clk);
        check("rdy before req", 160'(o_rdy), 160'(1));
        i_val = 1'b1; i_ctl = mode; i_dat_a = a; i_dat_b = b; i_add_term = t;
        exp_q.push_back(model(mode, a, b, t));
        @(posedge i_clk); #1;
        i_val = 1'b0;
        i_dat_a = rand_op(); i_dat_b = rand_op(); i_add_term = rand_op();
        i_ctl = 2'($urandom_range(0, 3));
        check("rdy after accept", 160'(o_rdy), 160'(0));
    endtask

    task automatic wait_result(input string tag, input int exp_lat, output logic [EXP_W-1:0] e);
        int lat;
        lat = 0;
        while (o_val !== 1'b1 && lat < 64) begin
            @(posedge i_clk); #1;
            lat++;
        end
        check({tag, " latency"}, 160'(lat), 160'(exp_lat));
        e = exp_q.pop_front();
        check_result(tag, e);
    endtask

    task automatic take(input string tag);
        @(negedge i_clk);
        i_rdy = 1'b1;
        @(posedge i_clk); #1;
        i_rdy = 1'b0;
        check({tag, " val after take"}, 160'(o_val), 160'(0));
        check({tag, " rdy after take"}, 160'(o_rdy), 160'(1));
    endtask

    function automatic int lat_of(input logic [1:0] mode);
        return (mode == 2'd0) ? N + 1 : 2 * N + 1;
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [EXP_W-1:0] e;
        logic [DW-1:0]    ones, t1, a, b, t;
        logic [1:0]       m;

        ones = fill(17'h0FFFF);
        t1   = '0;
        t1[D-1:0] = 17'h0FFFF;

        // Reset, with a request held across the release edge
        i_val = 1'b1; i_ctl = 2'd3; i_dat_a = ones; i_dat_b = ones;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset val", 160'(o_val), 160'(0));
        check("reset rdy", 160'(o_rdy), 160'(1));
        @(posedge i_clk);
        i_rst_n = 1'b1;
        #1;
        i_val = 1'b0;
        check("release dat", 160'(o_dat), 160'(0));
        check("release ovf", 160'(o_ovf), 160'(0));
        check("release ctl", 160'(o_ctl), 160'(0));
        @(posedge i_clk); #1;
        check("release not accepted", 160'(o_rdy), 160'(1));

        // FULL, all-0xFFFF operands
        send(2'd3, ones, ones, '0);
        wait_result("full ffff", 9, e);
        check("full ffff w0 const", 160'(o_dat[D-1:0]), 160'(1));
        check("full ffff w4 const", 160'(o_dat[4*D +: D]), 160'(17'h0FFFE));
        take("full ffff");

        // LOW, same operands
        send(2'd0, ones, ones, '0);
        wait_result("low ffff", 5, e);
        take("low ffff");

        // HIGH and FULL with add term in the lowest digit
        send(2'd1, ones, ones, t1);
        wait_result("high add", 9, e);
        take("high add");
        send(2'd3, ones, ones, t1);
        wait_result("full add", 9, e);
        take("full add");

        // SQUARE with all-ones 17-bit digits, b must not matter
        for (int r = 0; r < 2; r++) begin
            send(2'd2, fill(17'h1FFFF), rand_op(), '0);
            wait_result("square", 9, e);
            check("square ovf const", 160'(o_ovf), 160'(1));
            take("square");
        end

        // Back-pressure: result held while i_val pulses are ignored
        a = rand_op(); b = rand_op(); t = rand_op();
        send(2'd3, a, b, t);
        wait_result("bp", 9, e);
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            check("bp dat stable", 160'(o_dat), 160'(e[OW-1:0]));
            check("bp val held", 160'(o_val), 160'(1));
            check("bp rdy low", 160'(o_rdy), 160'(0));
            i_val = c[0];
            i_ctl = 2'($urandom_range(0, 3));
            i_dat_a = rand_op();
        end
        @(negedge i_clk);
        i_val = 1'b0;
        take("bp");
        repeat (12) @(posedge i_clk);
        #1;
        check("bp nothing queued", 160'(o_val), 160'(0));

        // Reset pulse while MUL processes row 2
        send(2'd3, rand_op(), rand_op(), rand_op());
        repeat (2) @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        check("midrst val", 160'(o_val), 160'(0));
        check("midrst rdy", 160'(o_rdy), 160'(1));
        check("midrst dat", 160'(o_dat), 160'(0));
        void'(exp_q.pop_front());
        @(negedge i_clk);
        i_rst_n = 1'b1;
        send(2'd3, ones, ones, t1);
        wait_result("after rst", 9, e);
        take("after rst");

        // Randomised requests across all modes
        for (int r = 0; r < 12; r++) begin
            m = 2'($urandom_range(0, 3));
            send(m, rand_op(), rand_op(), rand_op());
            wait_result($sformatf("rand%0d m%0d", r, m), lat_of(m), e);
            take("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
